// File: rtl/cdp_sq_window_pipe.sv
// CDP int8 sum-of-squares feeder: 9-tap channel window with zero-padded
// group edges, registered tap squares and load/length strobes for the sum stage.
module cdp_sq_window_pipe #(
  parameter int pINT8_BW = 9
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  input  logic [1:0]              reg2dp_normalz_len,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [pINT8_BW-1:0]     in_pd,
  input  logic                    in_last,
  output logic [2*pINT8_BW-2:0]   sq_pd_int8_0,
  output logic [2*pINT8_BW-2:0]   sq_pd_int8_1,
  output logic [2*pINT8_BW-2:0]   sq_pd_int8_2,
  output logic [2*pINT8_BW-2:0]   sq_pd_int8_3,
  output logic [2*pINT8_BW-2:0]   sq_pd_int8_4,
  output logic [2*pINT8_BW-2:0]   sq_pd_int8_5,
  output logic [2*pINT8_BW-2:0]   sq_pd_int8_6,
  output logic [2*pINT8_BW-2:0]   sq_pd_int8_7,
  output logic [2*pINT8_BW-2:0]   sq_pd_int8_8,
  output logic                    load_din_d,
  output logic                    load_din_2d,
  output logic                    len5,
  output logic                    len7,
  output logic                    len9
);

  localparam int BW = pINT8_BW;
  localparam int SW = 2*pINT8_BW-1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      len_q;
  logic [1:0]      len_eff;
  logic [3:0]      top;
  logic [BW-1:0]   w [9];
  logic [BW-1:0]   w_nxt [9];
  logic [8:0]      v;
  logic [8:0]      v_nxt;
  logic [SW-1:0]   sq [9];
  logic            acc;
  logic            shift;
  logic            emit;
  logic            clr;

  function automatic logic [SW-1:0] sq_f(input logic [BW-1:0] x);
    logic signed [2*BW-1:0] xe;
    logic signed [2*BW-1:0] p;
    xe = {{BW{x[BW-1]}}, x};
    p  = xe * xe;
    return p[SW-1:0];
  endfunction

  assign in_rdy  = (state != FLUSH);
  assign acc     = in_vld & in_rdy;
  assign shift   = acc | (state == FLUSH);
  // The opening accept must already use the new length.
  assign len_eff = (state == IDLE) ? reg2dp_normalz_len : len_q;
  assign top     = 4'd5 + {2'b00, len_eff};

  always_comb begin
    w_nxt = w;
    v_nxt = v;
    if (shift) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(top)) begin
          w_nxt[k] = w[k+1];
          v_nxt[k] = v[k+1];
        end
      end
      w_nxt[top] = acc ? in_pd : '0;
      v_nxt[top] = acc;
    end
  end

  assign emit = shift & v_nxt[4];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc) state_nxt = in_last ? FLUSH : RUN;
      RUN:     if (acc && in_last) state_nxt = FLUSH;
      FLUSH:   if (v_nxt[8:5] == 4'b0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign clr = (state == FLUSH) && (state_nxt == IDLE);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state       <= IDLE;
      len_q       <= '0;
      v           <= '0;
      load_din_d  <= 1'b0;
      load_din_2d <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        w[k]  <= '0;
        sq[k] <= '0;
      end
    end else begin
      state       <= state_nxt;
      load_din_d  <= emit;
      load_din_2d <= load_din_d;
      if (state == IDLE && acc) len_q <= reg2dp_normalz_len;
      v <= clr ? 9'b0 : v_nxt;
      for (int k = 0; k < 9; k++) begin
        w[k] <= clr ? '0 : w_nxt[k];
        if (emit) sq[k] <= sq_f(w_nxt[k]);
      end
    end
  end

  assign len5 = (len_q != 2'd0);
  assign len7 = len_q[1];
  assign len9 = &len_q;

  assign sq_pd_int8_0 = sq[0];
  assign sq_pd_int8_1 = sq[1];
  assign sq_pd_int8_2 = sq[2];
  assign sq_pd_int8_3 = sq[3];
  assign sq_pd_int8_4 = sq[4];
  assign sq_pd_int8_5 = sq[5];
  assign sq_pd_int8_6 = sq[6];
  assign sq_pd_int8_7 = sq[7];
  assign sq_pd_int8_8 = sq[8];

endmodule

// File: tb/tb_cdp_sq_window_pipe.sv
// Bench for cdp_sq_window_pipe: group table plus scoreboard of expected
// tap squares, with hand-written reset and corner sequences.
module tb_cdp_sq_window_pipe;

  logic              clk;
  logic              rstn;
  logic [1:0]        reg2dp_normalz_len;
  logic              in_vld;
  logic              in_rdy;
  logic [8:0]        in_pd;
  logic              in_last;
  logic [16:0]       sq0, sq1, sq2, sq3, sq4, sq5, sq6, sq7, sq8;
  logic              load_din_d;
  logic              load_din_2d;
  logic              len5, len7, len9;

  logic [8:0][16:0]  got;
  assign got = {sq8, sq7, sq6, sq5, sq4, sq3, sq2, sq1, sq0};

  cdp_sq_window_pipe #(.pINT8_BW(9)) dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rstn    (rstn),
    .reg2dp_normalz_len (reg2dp_normalz_len),
    .in_vld             (in_vld),
    .in_rdy             (in_rdy),
    .in_pd              (in_pd),
    .in_last            (in_last),
    .sq_pd_int8_0       (sq0),
    .sq_pd_int8_1       (sq1),
    .sq_pd_int8_2       (sq2),
    .sq_pd_int8_3       (sq3),
    .sq_pd_int8_4       (sq4),
    .sq_pd_int8_5       (sq5),
    .sq_pd_int8_6       (sq6),
    .sq_pd_int8_7       (sq7),
    .sq_pd_int8_8       (sq8),
    .load_din_d         (load_din_d),
    .load_din_2d        (load_din_2d),
    .len5               (len5),
    .len7               (len7),
    .len9               (len9)
  );

  typedef struct {
    logic [1:0] len;
    logic [1:0] len_mid;
    int         n;
    int         s[8];
    bit         tog;
    bit         hold;
    int         flush;
    logic [2:0] lens;
  } vec_t;

  vec_t              tbl[8];
  logic [8:0][16:0]  q[$];
  int                vectors = 0;
  int                miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [191:0] g,
                     input logic [191:0] e);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, g, e);
    end
  endtask

  // Tap k of emit j: sample j+k-4 of the group, zero outside the group
  // and above the insertion slot 4+h.
  function automatic logic [8:0][16:0] model(input int h, input int n,
                                             input int s[8], input int j);
    logic [8:0][16:0] r;
    int idx;
    int val;
    for (int k = 0; k < 9; k++) begin
      idx = j + k - 4;
      val = (k <= 4 + h && idx >= 0 && idx < n) ? s[idx] : 0;
      r[k] = 17'(val * val);
    end
    return r;
  endfunction

  initial begin
    logic prev_ld;
    logic [8:0][16:0] e;
    prev_ld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_ld = 1'b0;
      end else begin
        if (prev_ld || load_din_2d) chk("load_din_2d", load_din_2d, prev_ld);
        if (load_din_d) begin
          if (q.size() == 0) begin
            chk("unexpected_emit", 1, 0);
          end else begin
            e = q.pop_front();
            chk("tap_squares", got, e);
          end
        end
        prev_ld = load_din_d;
      end
    end
  end

  task automatic drive_one(input logic [8:0] d, input logic last,
                           output bit ok);
    ok = 1'b0;
    in_vld  = 1'b1;
    in_pd   = d;
    in_last = last;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_vld  = 1'b0;
    in_last = 1'b0;
    in_pd   = 9'($urandom);
  endtask

  task automatic run_group(input int i);
    vec_t g;
    int   h;
    int   cnt;
    bit   ok;
    g = tbl[i];
    h = int'(g.len) + 1;
    reg2dp_normalz_len = g.len;
    for (int j = 0; j < g.n; j++) q.push_back(model(h, g.n, g.s, j));
    for (int j = 0; j < g.n; j++) begin
      drive_one(9'(g.s[j]), j == g.n - 1, ok);
      if (!ok) chk("accept_timeout", 0, 1);
      if (j == 0) begin
        chk("len_decode", {len5, len7, len9}, g.lens);
        reg2dp_normalz_len = g.len_mid;
      end
      if (g.tog && j < g.n - 1) begin
        @(posedge clk);
        #1;
      end
    end
    if (g.hold) begin
      in_vld = 1'b1;
      in_pd  = 9'h1aa;
    end
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_rdy) break;
      cnt++;
    end
    in_vld = 1'b0;
    chk("flush_cycles", cnt, g.flush);
    repeat (2) @(posedge clk);
    #1;
    chk("emit_count", q.size(), 0);
  endtask

  task automatic set_vec(input int i, input logic [1:0] len,
                         input logic [1:0] mid, input int n, input bit tog,
                         input bit hold, input int fl, input logic [2:0] lens);
    tbl[i].len     = len;
    tbl[i].len_mid = mid;
    tbl[i].n       = n;
    tbl[i].tog     = tog;
    tbl[i].hold    = hold;
    tbl[i].flush   = fl;
    tbl[i].lens    = lens;
  endtask

  initial begin
    bit ok;
    rstn = 1'b0;
    in_vld = 1'b0;
    in_pd = '0;
    in_last = 1'b0;
    reg2dp_normalz_len = 2'd0;

    set_vec(0, 2'd0, 2'd0, 3, 0, 0, 1, 3'b000);
    tbl[0].s = '{1, 2, 3, 0, 0, 0, 0, 0};
    set_vec(1, 2'd3, 2'd3, 1, 0, 0, 4, 3'b111);
    tbl[1].s = '{-128, 0, 0, 0, 0, 0, 0, 0};
    set_vec(2, 2'd1, 2'd1, 5, 0, 1, 2, 3'b100);
    tbl[2].s = '{-256, 255, 0, 7, 1, 0, 0, 0};
    set_vec(3, 2'd1, 2'd1, 1, 0, 0, 2, 3'b100);
    tbl[3].s = '{2, 0, 0, 0, 0, 0, 0, 0};
    set_vec(4, 2'd2, 2'd2, 6, 1, 0, 3, 3'b110);
    tbl[4].s = '{1, 2, 3, 4, 5, 6, 0, 0};
    set_vec(5, 2'd0, 2'd3, 4, 0, 0, 1, 3'b000);
    tbl[5].s = '{5, -3, 4, 9, 0, 0, 0, 0};
    set_vec(6, 2'd3, 2'd3, 3, 0, 1, 4, 3'b111);
    tbl[6].s = '{10, -20, 30, 0, 0, 0, 0, 0};
    set_vec(7, 2'd0, 2'd0, 1, 0, 0, 1, 3'b000);
    tbl[7].s = '{-7, 0, 0, 0, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {in_rdy, load_din_d, load_din_2d, len5, len7, len9, got},
        {1'b1, 5'b0, 153'b0});
    @(posedge clk);
    #1;
    rstn = 1'b1;

    run_group(0);
    run_group(1);
    chk("len9_sq4", sq4, 17'd16384);
    run_group(2);
    run_group(3);
    run_group(4);
    chk("len7_sq4_hold", sq4, 17'd36);
    run_group(5);
    run_group(6);

    reg2dp_normalz_len = 2'd1;
    drive_one(9'd3, 1'b0, ok);
    if (!ok) chk("accept_timeout", 0, 1);
    drive_one(9'd4, 1'b0, ok);
    if (!ok) chk("accept_timeout", 0, 1);
    #2;
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_reset", {in_rdy, load_din_d, load_din_2d, len5, len7, len9, got},
        {1'b1, 5'b0, 153'b0});
    @(posedge clk);
    #1;
    rstn = 1'b1;
    run_group(7);
    chk("post_reset_sq4", sq4, 17'd49);

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
